// File: rtl/chain_sched_pkg.sv
// Shared types and default widths for the delay-chain toggle scheduler.
package chain_sched_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int LAT_W_DEF = 24;
  localparam int HB_W_DEF  = 20;

  // lat_min holds all-ones until the first edge of a run comes back
  localparam logic [LAT_W_DEF-1:0] LAT_INIT_MIN = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/chain_sync2.sv
// Two-flop synchroniser bringing the asynchronous chain output into the clk domain.
module chain_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/chain_toggle_sched.sv
// Launches a programmed number of edges into the delay chain and measures each round trip.
// Optional heartbeat pulse while busy is built when CHAIN_SCHED_HEARTBEAT_EN is defined.
module chain_toggle_sched
  import chain_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LAT_W = LAT_W_DEF,
  parameter int HB_W  = HB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_toggles,
  input  logic [CNT_W-1:0] period,
  input  logic [LAT_W-1:0] timeout,
  input  logic             chain_out,
  output logic             chain_in,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             aborted,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [LAT_W-1:0] lat_last,
  output logic [LAT_W-1:0] lat_max,
  output logic [LAT_W-1:0] lat_min,
  output logic             heartbeat
);

  localparam logic [LAT_W-1:0] LAT_MIN_RST = {LAT_W{LAT_INIT_MIN[0]}};

  state_t           state, state_nxt;
  logic             sync_out;
  logic [CNT_W-1:0] n_tog_q, period_q, per_ctr, per_inc;
  logic [LAT_W-1:0] timeout_q, lat_ctr, lat_inc;
  logic             accept, launch, match, match_upd, to_hit, abort_hit;

  chain_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (chain_out),
    .q     (sync_out)
  );

  assign busy    = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_GAP);
  assign done    = (state == S_DONE);
  assign match   = (sync_out == chain_in);
  assign lat_inc = (lat_ctr == '1) ? lat_ctr : lat_ctr + 1'b1;
  assign per_inc = (per_ctr == '1) ? per_ctr : per_ctr + 1'b1;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    launch    = 1'b0;
    match_upd = 1'b0;
    to_hit    = 1'b0;
    abort_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_toggles == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // a returning edge beats a timeout landing in the same cycle
        if (match) begin
          match_upd = 1'b1;
          if (toggle_cnt == n_tog_q)   state_nxt = S_DONE;
          else if (per_inc >= period_q) state_nxt = S_LAUNCH;
          else                          state_nxt = S_GAP;
        end else if (lat_ctr == timeout_q) begin
          to_hit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        if (per_inc >= period_q) state_nxt = S_LAUNCH;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && busy) begin
      abort_hit = 1'b1;
      launch    = 1'b0;
      match_upd = 1'b0;
      to_hit    = 1'b0;
      state_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      chain_in    <= 1'b0;
      n_tog_q     <= '0;
      period_q    <= '0;
      timeout_q   <= '0;
      per_ctr     <= '0;
      lat_ctr     <= '0;
      toggle_cnt  <= '0;
      lat_last    <= '0;
      lat_max     <= '0;
      lat_min     <= LAT_MIN_RST;
      err_timeout <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        n_tog_q     <= num_toggles;
        period_q    <= period;
        timeout_q   <= timeout;
        toggle_cnt  <= '0;
        lat_last    <= '0;
        lat_max     <= '0;
        lat_min     <= LAT_MIN_RST;
        err_timeout <= 1'b0;
        aborted     <= 1'b0;
      end
      if (launch) begin
        chain_in   <= ~chain_in;
        toggle_cnt <= toggle_cnt + 1'b1;
        lat_ctr    <= LAT_W'(1);
        per_ctr    <= CNT_W'(1);
      end
      if (state == S_WAIT) begin
        lat_ctr <= lat_inc;
        per_ctr <= per_inc;
      end
      if (state == S_GAP) per_ctr <= per_inc;
      if (match_upd) begin
        lat_last <= lat_ctr;
        if (lat_ctr > lat_max) lat_max <= lat_ctr;
        if (lat_ctr < lat_min) lat_min <= lat_ctr;
      end
      if (to_hit)    err_timeout <= 1'b1;
      if (abort_hit) aborted     <= 1'b1;
    end
  end

`ifdef CHAIN_SCHED_HEARTBEAT_EN
  logic [HB_W-1:0] hb_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hb_ctr <= '0;
    else if (accept) hb_ctr <= '0;
    else             hb_ctr <= hb_ctr + 1'b1;
  end

  assign heartbeat = busy && (hb_ctr == '1);
`else
  if (HB_W < 1) begin : g_hb_w_invalid
  end

  assign heartbeat = 1'b0;
`endif

endmodule
